// File: rtl/uart_pkg.sv
// Shared UART constants: default oversampling/frame width and the RX state encodings.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    // Counter width that stays legal when the count range collapses to one value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input; resets to 1.
// Latency 2 clk; no flow control.
module uart_bit_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: start, DATA_BITS LSB-first, one stop bit, paced by an oversampling tick.
// Valid/error pulse 1 clk after the stop mid-sample tick (+2 clk sync); no backpressure.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_Sample_Tick,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Valid,
    output logic                 o_Rx_Active,
    output logic                 o_Frame_Error
);

    localparam int TICK_W = cnt_width(OVERSAMPLE);
    localparam int BIT_W  = cnt_width(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 w_rx;
    logic [2:0]           r_state, w_state_nxt;
    logic [TICK_W-1:0]    r_tick_cnt, w_tick_cnt_nxt;
    logic [BIT_W-1:0]     r_bit_idx, w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_valid, r_ferr, r_active;
    logic                 w_at_mid, w_at_last;
    logic                 w_sample_data, w_valid_nxt, w_ferr_nxt, w_active_nxt;

    uart_bit_sync u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (i_Rx_Serial),
        .o_sync  (w_rx)
    );

    assign w_at_mid  = i_Sample_Tick && (r_tick_cnt == TICK_MID);
    assign w_at_last = i_Sample_Tick && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RX_IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        case (r_state)
            RX_IDLE: begin
                if (i_Sample_Tick && !w_rx) begin
                    w_state_nxt    = RX_START;
                    w_tick_cnt_nxt = '0;
                end
            end
            RX_START: begin
                if (w_at_mid) begin
                    w_state_nxt    = w_rx ? RX_IDLE : RX_DATA;
                    w_tick_cnt_nxt = '0;
                    w_bit_idx_nxt  = '0;
                end else if (i_Sample_Tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_at_last) begin
                    w_tick_cnt_nxt = '0;
                    if (r_bit_idx == BIT_LAST) w_state_nxt = RX_STOP;
                    else                       w_bit_idx_nxt = r_bit_idx + 1'b1;
                end else if (i_Sample_Tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (w_at_last) begin
                    w_state_nxt    = w_rx ? RX_IDLE : RX_BREAK;
                    w_tick_cnt_nxt = '0;
                end else if (i_Sample_Tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                end
            end
            // A held-low line must return high before another start is considered.
            RX_BREAK: begin
                if (i_Sample_Tick && w_rx) w_state_nxt = RX_IDLE;
            end
            default: begin
                w_state_nxt    = RX_IDLE;
                w_tick_cnt_nxt = '0;
                w_bit_idx_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_sample_data = (r_state == RX_DATA) && w_at_last;
        w_valid_nxt   = (r_state == RX_STOP) && w_at_last && w_rx;
        w_ferr_nxt    = (r_state == RX_STOP) && w_at_last && !w_rx;
        w_active_nxt  = (w_state_nxt == RX_DATA) || (w_state_nxt == RX_STOP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_valid  <= w_valid_nxt;
            r_ferr   <= w_ferr_nxt;
            r_active <= w_active_nxt;
            if (w_sample_data) r_shift[r_bit_idx] <= w_rx;
            if (w_valid_nxt)   r_byte <= r_shift;
        end
    end

    assign o_Rx_Byte     = r_byte;
    assign o_Rx_Valid    = r_valid;
    assign o_Rx_Active   = r_active;
    assign o_Frame_Error = r_ferr;

endmodule
